mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk_in input 1 system clock; rst_in input 1 asynchronous active-low reset; rdy_in input 1 global pause, all state frozen when low.
REQ-002 SHALL have instruction port: if_req input 1 fetch request; if_addr input 32 word address; if_done output 1 one-cycle completion pulse; if_data output 32 fetched word, little-endian.
REQ-003 SHALL have data port: ls_req input 1; ls_wr input 1 (1=store); ls_addr input 32; ls_size input 2 (00=1B, 01=2B, 10=4B); ls_wdata input 32; ls_done output 1 pulse; ls_rdata output 32, zero-extended.
REQ-004 SHALL have memory port: mem_din input 8 (RAM read byte, valid one cycle after address); mem_dout output 8; mem_a output 32; mem_wr output 1 (1=write); io_buffer_full input 1.
REQ-005 SHALL have clear input 1: pipeline flush from reorder buffer.

Function
REQ-006 Requests SHALL be level: requester holds req and operands stable until its done pulse; address, size, wdata are latched at acceptance.
REQ-007 States: IDLE, READ, WRITE; accept only in IDLE; IDLE->READ for fetch or load, IDLE->WRITE for store; READ/WRITE->IDLE after final byte or abort.
REQ-008 Arbitration in IDLE: only one req -> grant it; both -> grant the port not granted last (1-bit last_grant); last_grant resets to instruction, so data wins first tie.
REQ-009 Byte count n: fetch 4; data 1/2/4 per ls_size; ls_size=11 treated as 4.
REQ-010 Read timing: req first seen in IDLE at cycle T -> mem_a=base+k, mem_wr=0 in cycle T+1+k (k=0..n-1); byte k captured from mem_din in cycle T+2+k into bit slice [8k+7:8k]; done pulses in cycle T+n+2 with data valid that cycle.
REQ-011 Write timing: mem_a=base+k, mem_dout=wdata[8k+7:8k], mem_wr=1 in cycle T+1+k; ls_done pulses in cycle T+n.
REQ-012 IO stall: while in WRITE and io_buffer_full=1 and addr[17:16]=11, the next byte SHALL NOT be issued (mem_wr=0, counter held) until io_buffer_full falls.
REQ-013 Outside active byte issue, mem_wr SHALL be 0 and mem_dout 0; mem_a holds last value.
REQ-014 Address arithmetic SHALL be 32-bit wrap-around (0xFFFFFFFF+1 = 0).
REQ-015 clear=1 in IDLE: no acceptance that cycle. clear during READ (fetch or load): abort next edge, no done pulse, -> IDLE. clear during WRITE: ignored, store completes.
REQ-016 done outputs SHALL be single-cycle pulses, never both high in one cycle; if_data/ls_rdata hold until next completion on that port.
REQ-017 rdy_in=0 SHALL freeze state, counter, outputs (done pulse extends while frozen); mem_wr forced 0 while frozen.

Reset
REQ-018 rst_in low SHALL asynchronously force: state IDLE, counter 0, last_grant instruction, if_done=ls_done=0, if_data=ls_rdata=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-019 Reset mid-transaction SHALL abandon it with no done pulse; a partially written store remains partial.

Structure
REQ-020 Shared package SHALL hold state encoding, size codes, IO address-match constant (2'b11 on [17:16]).
REQ-021 One sub-module natural: mem_byte_shifter (assembles/disassembles bytes by counter); arbitration and FSM stay in mem_arbiter.

Verification
REQ-022 Fetch 0x1000, RAM bytes 13 05 00 00 -> if_done cycle T+6, if_data=0x00000513.
REQ-023 Store 2B 0x0000BEEF to 0x200 -> writes EF@0x200 T+1, BE@0x201 T+2, ls_done T+2, mem_wr low after.
REQ-024 if_req and ls_req together from reset -> ls first, then if, then ls again with both held: strict alternation.
REQ-025 Fetch in flight, clear at T+3 -> no if_done, IDLE at T+4; concurrent store with clear -> completes with ls_done.
REQ-026 Store 1B 0x41 to 0x30000 with io_buffer_full high 5 cycles -> mem_wr stays 0 those cycles, byte issued first cycle after fall.
REQ-027 rst_in low at T+2 of 4B load -> all outputs zero immediately, no ls_done; new request after release serviced normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the memory arbiter: FSM state
//               encoding, access size codes, grant encoding, IO address match
//               and a size-to-byte-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    localparam int BYTE_W = 8;

    // Data-port access size codes
    localparam logic [1:0] SIZE_1B   = 2'b00;
    localparam logic [1:0] SIZE_2B   = 2'b01;
    localparam logic [1:0] SIZE_4B   = 2'b10;

    // addr[17:16] value that selects the memory-mapped IO region
    localparam logic [1:0] IO_ADDR_MATCH = 2'b11;

    // last_grant encoding
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    // Number of bytes moved for a data-port access; the reserved code 2'b11
    // behaves as a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_1B: n = 3'd1;
            SIZE_2B: n = 3'd2;
            SIZE_4B: n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the arbiter, its two requesters
//               (instruction fetch and load/store) and the byte-wide RAM.
//   Instruction port : if_req, if_addr -> if_done, if_data
//   Data port        : ls_req, ls_wr, ls_addr, ls_size, ls_wdata
//                      -> ls_done, ls_rdata
//   Memory port      : mem_din, io_buffer_full -> mem_dout, mem_a, mem_wr
//   Modports         : slave  = arbiter side
//                      master = requester / memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        input  mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        output mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata,
        input  mem_dout, mem_a, mem_wr
    );

endinterface
`default_nettype wire

// File: rtl/mem_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_shifter
// Description : Purely combinational byte lane steering. Inserts a received
//               RAM byte into the read assembly word at a byte index, and
//               extracts the write byte for a byte index (little-endian).
//   i_rbuf/i_rd_idx/i_din -> o_rbuf  : read assembly
//   i_wdata/i_wr_idx      -> o_wbyte : write disassembly
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_shifter
    import mem_arbiter_pkg::*;
(
    input  wire logic [4*BYTE_W-1:0] i_rbuf,
    input  wire logic [1:0]          i_rd_idx,
    input  wire logic [BYTE_W-1:0]   i_din,
    output logic      [4*BYTE_W-1:0] o_rbuf,
    input  wire logic [4*BYTE_W-1:0] i_wdata,
    input  wire logic [1:0]          i_wr_idx,
    output logic      [BYTE_W-1:0]   o_wbyte
);

    always_comb begin
        o_rbuf = i_rbuf;
        o_rbuf[{i_rd_idx, 3'b000} +: BYTE_W] = i_din;
    end

    assign o_wbyte = i_wdata[{i_wr_idx, 3'b000} +: BYTE_W];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a byte-wide RAM between the instruction-fetch port
//               and the load/store port. Round-robin on ties, sequential byte
//               transfers, IO write back-pressure, flush and global pause.
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   rdy_in  : global pause, all state frozen while low
//   clear   : pipeline flush (aborts reads, blocks acceptance in IDLE)
//   bus     : mem_arbiter_if.slave (requester and RAM signals)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  wire logic    clk_in,
    input  wire logic    rst_in,
    input  wire logic    rdy_in,
    input  wire logic    clear,
    mem_arbiter_if.slave bus
);

    arb_state_t  r_state;
    logic [2:0]  r_cnt;        // READ: cycle index; WRITE: byte index
    logic [2:0]  r_nbytes;
    logic        r_last_grant; // also identifies the port of the active access
    logic        r_io_region;
    logic        r_if_done;
    logic        r_ls_done;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_rdata;
    logic [31:0] r_rbuf;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;

    logic        w_grant_ls;
    logic        w_accept;
    logic        w_io_stall;
    logic        w_issue;
    logic        w_wr_last;
    logic        w_ls_wr_done;
    logic [1:0]  w_rd_idx;
    logic [1:0]  w_wr_idx;
    logic [31:0] w_rbuf_next;
    logic [7:0]  w_wr_byte;

    assign w_grant_ls = (bus.if_req && bus.ls_req) ? (r_last_grant == GRANT_IF)
                                                   : bus.ls_req;

    // A requester still holds req during its own done cycle, so acceptance
    // waits until the read-done pulse has gone to avoid servicing it twice.
    assign w_accept = (r_state == ST_IDLE) && !clear && !r_if_done && !r_ls_done
                   && (bus.if_req || bus.ls_req);

    assign w_io_stall   = (r_state == ST_WRITE) && bus.io_buffer_full && r_io_region;
    assign w_issue      = (r_state == ST_WRITE) && !w_io_stall && rdy_in;
    assign w_wr_last    = (r_cnt == r_nbytes - 3'd1);
    // Store completion coincides with the final byte actually leaving, so it
    // follows the IO stall; it is not gated by rdy_in so it extends while frozen.
    assign w_ls_wr_done = (r_state == ST_WRITE) && w_wr_last && !w_io_stall;

    // In READ, cycle index j captures byte j-1 from the RAM.
    assign w_rd_idx = r_cnt[1:0] - 2'd1;
    assign w_wr_idx = r_cnt[1:0] + 2'd1;

    mem_byte_shifter u_shifter (
        .i_rbuf   (r_rbuf),
        .i_rd_idx (w_rd_idx),
        .i_din    (bus.mem_din),
        .o_rbuf   (w_rbuf_next),
        .i_wdata  (r_wdata),
        .i_wr_idx (w_wr_idx),
        .o_wbyte  (w_wr_byte)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_nbytes     <= 3'd0;
            r_last_grant <= GRANT_IF;
            r_io_region  <= 1'b0;
            r_if_done    <= 1'b0;
            r_ls_done    <= 1'b0;
            r_if_data    <= 32'd0;
            r_ls_rdata   <= 32'd0;
            r_rbuf       <= 32'd0;
            r_wdata      <= 32'd0;
            r_mem_a      <= 32'd0;
            r_mem_dout   <= 8'd0;
        end else if (rdy_in) begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant_ls ? GRANT_LS : GRANT_IF;
                        r_cnt        <= 3'd0;
                        r_rbuf       <= 32'd0;
                        if (w_grant_ls) begin
                            r_mem_a     <= bus.ls_addr;
                            r_nbytes    <= size_to_bytes(bus.ls_size);
                            r_wdata     <= bus.ls_wdata;
                            r_mem_dout  <= bus.ls_wdata[7:0];
                            r_io_region <= (bus.ls_addr[17:16] == IO_ADDR_MATCH);
                            r_state     <= bus.ls_wr ? ST_WRITE : ST_READ;
                        end else begin
                            r_mem_a     <= bus.if_addr;
                            r_nbytes    <= 3'd4;
                            r_io_region <= 1'b0;
                            r_state     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (clear) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_rbuf <= w_rbuf_next;
                        end
                        if (r_cnt + 3'd1 < r_nbytes) begin
                            r_mem_a <= r_mem_a + 32'd1;
                        end
                        if (r_cnt == r_nbytes) begin
                            r_state <= ST_IDLE;
                            if (r_last_grant == GRANT_LS) begin
                                r_ls_done  <= 1'b1;
                                r_ls_rdata <= w_rbuf_next;
                            end else begin
                                r_if_done  <= 1'b1;
                                r_if_data  <= w_rbuf_next;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!w_io_stall) begin
                        if (w_wr_last) begin
                            r_state    <= ST_IDLE;
                            r_mem_dout <= 8'd0;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_mem_a    <= r_mem_a + 32'd1;
                            r_mem_dout <= w_wr_byte;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_done  = r_if_done;
    assign bus.ls_done  = r_ls_done | w_ls_wr_done;
    assign bus.if_data  = r_if_data;
    assign bus.ls_rdata = r_ls_rdata;
    assign bus.mem_a    = r_mem_a;
    assign bus.mem_wr   = w_issue;
    assign bus.mem_dout = w_issue ? r_mem_dout : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a byte RAM model and
//               a transaction-level reference for arbitration and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit          m_last_ls;
    logic [31:0] m_if_data;
    logic [31:0] m_ls_rdata;

    // Byte RAM: unwritten locations return an address-derived pattern
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk_in) begin
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= ram_rd(bus.mem_a);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFE;
            1:       return $urandom & 32'h0000_0FFF;
            default: return $urandom & 32'hFFFC_FFFF;
        endcase
    endfunction

    // Services whichever request the reference arbitration picks from the
    // currently driven request lines, checking every cycle of the transfer.
    // Called in the acceptance cycle; returns in the first cycle a new
    // request can be accepted.
    task automatic expect_service(input bit pulse_clear);
        bit          win_ls;
        bit          wr;
        int          n;
        logic [31:0] base;
        logic [31:0] wd;
        logic [31:0] exp;
        if (bus.if_req && bus.ls_req) win_ls = !m_last_ls;
        else                          win_ls = bus.ls_req;
        m_last_ls = win_ls;
        if (win_ls) begin
            base = bus.ls_addr;
            wr   = bus.ls_wr;
            n    = (bus.ls_size == 2'b00) ? 1 : (bus.ls_size == 2'b01) ? 2 : 4;
            wd   = bus.ls_wdata;
        end else begin
            base = bus.if_addr;
            wr   = 1'b0;
            n    = 4;
            wd   = 32'd0;
        end
        exp = 32'd0;
        for (int k = 0; k < n; k++)
            exp = exp | ({24'd0, ram_rd(base + 32'(k))} << (8 * k));
        tick();
        if (pulse_clear) clear = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk("mem_a", bus.mem_a, base + 32'(k));
            chk("mem_wr", {31'd0, bus.mem_wr}, {31'd0, wr});
            chk("mem_dout", {24'd0, bus.mem_dout}, wr ? {24'd0, wd[8*k +: 8]} : 32'd0);
            chk("if_done_busy", {31'd0, bus.if_done}, 32'd0);
            chk("ls_done_busy", {31'd0, bus.ls_done}, (wr && k == n - 1) ? 32'd1 : 32'd0);
            if (wr && k == n - 1) bus.ls_req = 1'b0;
            tick();
        end
        clear = 1'b0;
        chk("mem_wr_after", {31'd0, bus.mem_wr}, 32'd0);
        chk("if_done_gap", {31'd0, bus.if_done}, 32'd0);
        chk("ls_done_gap", {31'd0, bus.ls_done}, 32'd0);
        if (!wr) begin
            tick();
            if (win_ls) m_ls_rdata = exp;
            else        m_if_data  = exp;
            chk("if_done_pulse", {31'd0, bus.if_done}, win_ls ? 32'd0 : 32'd1);
            chk("ls_done_pulse", {31'd0, bus.ls_done}, win_ls ? 32'd1 : 32'd0);
            if (win_ls) bus.ls_req = 1'b0;
            else        bus.if_req = 1'b0;
            tick();
            chk("if_done_end", {31'd0, bus.if_done}, 32'd0);
            chk("ls_done_end", {31'd0, bus.ls_done}, 32'd0);
        end
        chk("if_data", bus.if_data, m_if_data);
        chk("ls_rdata", bus.ls_rdata, m_ls_rdata);
    endtask

    task automatic set_ls(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd);
        bus.ls_req   = 1'b1;
        bus.ls_wr    = wr;
        bus.ls_addr  = a;
        bus.ls_size  = sz;
        bus.ls_wdata = wd;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_done"},  {31'd0, bus.if_done}, 32'd0);
        chk({tag, "_ls_done"},  {31'd0, bus.ls_done}, 32'd0);
        chk({tag, "_if_data"},  bus.if_data, 32'd0);
        chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
        chk({tag, "_mem_a"},    bus.mem_a, 32'd0);
        chk({tag, "_mem_dout"}, {24'd0, bus.mem_dout}, 32'd0);
        chk({tag, "_mem_wr"},   {31'd0, bus.mem_wr}, 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = 32'd0;
        bus.ls_size = 2'b00; bus.ls_wdata = 32'd0; bus.io_buffer_full = 1'b0;
        m_last_ls = 1'b0; m_if_data = 32'd0; m_ls_rdata = 32'd0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        #2;
        check_all_zero("reset");
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // Simultaneous requests straight out of reset: ls, if, ls, if
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
        set_ls(1'b0, 32'h0000_2000, 2'b01, 32'd0);
        expect_service(1'b0);
        chk("tie_first_is_ls", {31'd0, m_last_ls}, 32'd1);
        set_ls(1'b0, 32'h0000_2004, 2'b10, 32'd0);
        expect_service(1'b0);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
        expect_service(1'b0);
        expect_service(1'b0);

        // Fetch of a known instruction word
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
        expect_service(1'b0);
        chk("fetch_word", bus.if_data, 32'h0000_0513);

        // Two-byte store
        set_ls(1'b1, 32'h0000_0200, 2'b01, 32'h0000_BEEF);
        expect_service(1'b0);
        chk("ram_200", {24'd0, ram_rd(32'h200)}, 32'h0000_00EF);
        chk("ram_201", {24'd0, ram_rd(32'h201)}, 32'h0000_00BE);

        // Fetch aborted by clear at T+3; arbiter must be idle at T+4
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
        m_last_ls = 1'b0;
        tick(); tick(); tick();
        clear = 1'b1; bus.if_req = 1'b0;
        tick();
        clear = 1'b0;
        chk("abort_if_done", {31'd0, bus.if_done}, 32'd0);
        set_ls(1'b0, 32'h0000_1001, 2'b00, 32'd0);
        expect_service(1'b0);

        // Store with clear asserted throughout still completes
        set_ls(1'b1, 32'h0000_0300, 2'b10, 32'hCAFE_F00D);
        expect_service(1'b1);

        // Clear in IDLE blocks acceptance for that cycle
        set_ls(1'b0, 32'h0000_0300, 2'b10, 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_service(1'b0);
        chk("store_readback", m_ls_rdata, 32'hCAFE_F00D);

        // IO store held off by a full buffer for 5 cycles
        set_ls(1'b1, 32'h0003_0000, 2'b00, 32'h0000_0041);
        bus.io_buffer_full = 1'b1;
        m_last_ls = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("io_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
            chk("io_stall_done", {31'd0, bus.ls_done}, 32'd0);
            tick();
        end
        bus.io_buffer_full = 1'b0;
        #1;
        chk("io_wr", {31'd0, bus.mem_wr}, 32'd1);
        chk("io_a", bus.mem_a, 32'h0003_0000);
        chk("io_dout", {24'd0, bus.mem_dout}, 32'h0000_0041);
        chk("io_done", {31'd0, bus.ls_done}, 32'd1);
        bus.ls_req = 1'b0;
        tick();
        chk("io_wr_after", {31'd0, bus.mem_wr}, 32'd0);

        // Non-IO store is unaffected by a full IO buffer
        bus.io_buffer_full = 1'b1;
        set_ls(1'b1, 32'h0002_0100, 2'b01, 32'h0000_1234);
        expect_service(1'b0);
        bus.io_buffer_full = 1'b0;

        // Pause during a load and during its done pulse
        set_ls(1'b0, 32'h0000_5000, 2'b00, 32'd0);
        m_last_ls = 1'b1;
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_mem_a", bus.mem_a, 32'h0000_5000);
            chk("frz_done", {31'd0, bus.ls_done}, 32'd0);
        end
        rdy_in = 1'b1;
        tick(); tick();
        m_ls_rdata = {24'd0, ram_rd(32'h0000_5000)};
        chk("frz_ld_done", {31'd0, bus.ls_done}, 32'd1);
        chk("frz_ld_data", bus.ls_rdata, m_ls_rdata);
        rdy_in = 1'b0; bus.ls_req = 1'b0;
        tick();
        chk("frz_done_ext1", {31'd0, bus.ls_done}, 32'd1);
        tick();
        chk("frz_done_ext2", {31'd0, bus.ls_done}, 32'd1);
        rdy_in = 1'b1;
        tick();
        chk("frz_done_end", {31'd0, bus.ls_done}, 32'd0);

        // Pause forces mem_wr low during a store byte
        set_ls(1'b1, 32'h0000_6000, 2'b00, 32'h0000_0077);
        tick();
        rdy_in = 1'b0;
        #1;
        chk("frz_wr", {31'd0, bus.mem_wr}, 32'd0);
        rdy_in = 1'b1;
        #1;
        chk("unfrz_wr", {31'd0, bus.mem_wr}, 32'd1);
        chk("unfrz_done", {31'd0, bus.ls_done}, 32'd1);
        bus.ls_req = 1'b0;
        tick();

        // Reset in the middle of a 4-byte load
        set_ls(1'b0, 32'h0000_4000, 2'b10, 32'd0);
        tick(); tick();
        rst_in = 1'b0;
        #1;
        check_all_zero("midrst");
        m_last_ls = 1'b0; m_if_data = 32'd0; m_ls_rdata = 32'd0;
        bus.ls_req = 1'b0;
        tick();
        chk("midrst_done", {31'd0, bus.ls_done}, 32'd0);
        tick();
        rst_in = 1'b1;
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
        set_ls(1'b0, 32'h0000_4000, 2'b10, 32'd0);
        expect_service(1'b0);
        expect_service(1'b0);

        // Randomised traffic on both ports
        for (int it = 0; it < 40; it++) begin
            if (!bus.if_req && $urandom_range(0, 2) != 0) begin
                bus.if_req = 1'b1; bus.if_addr = rand_addr();
            end
            if (!bus.ls_req && $urandom_range(0, 2) != 0)
                set_ls(1'($urandom_range(0, 1)), rand_addr(), 2'($urandom_range(0, 3)), $urandom);
            if (!bus.if_req && !bus.ls_req) begin
                bus.if_req = 1'b1; bus.if_addr = rand_addr();
            end
            expect_service(1'b0);
        end
        while (bus.if_req || bus.ls_req) expect_service(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
